// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad stand-in: plays one key press onto active-low column lines.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 1000,
  parameter int BOUNCE_CYCLES = 64,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press_valid,
  input  logic [3:0] press_key,
  output logic       press_ready,
  input  logic       bounce_en,
  input  logic       cancel,
  input  logic [3:0] key_row,
  output logic [3:0] cols,
  output logic       contact,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       lfsr;
  logic [7:0]       lfsr_nxt;
  logic [3:0]       key_q;
  logic             bounce_q;

  // x^8+x^6+x^5+x^4+1 is primitive, so a non-zero seed never reaches zero.
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= lfsr_nxt;
    end
  end

  // contact is registered alongside the LFSR so it equals lfsr[0] during bounce phases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      key_q       <= 4'd0;
      bounce_q    <= 1'b0;
      contact     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      press_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      if (cancel && state != IDLE) begin
        state       <= IDLE;
        cnt         <= '0;
        contact     <= 1'b0;
        busy        <= 1'b0;
        press_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (press_valid && !cancel) begin
              key_q       <= press_key;
              bounce_q    <= bounce_en;
              cnt         <= '0;
              busy        <= 1'b1;
              press_ready <= 1'b0;
              if (bounce_en) begin
                state   <= BOUNCE_IN;
                contact <= lfsr_nxt[0];
              end else begin
                state   <= HOLD;
                contact <= 1'b1;
              end
            end
          end
          BOUNCE_IN: begin
            if (cnt == BOUNCE_LAST) begin
              state   <= HOLD;
              cnt     <= '0;
              contact <= 1'b1;
            end else begin
              cnt     <= cnt + CNT_W'(1);
              contact <= lfsr_nxt[0];
            end
          end
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              cnt <= '0;
              if (bounce_q) begin
                state   <= BOUNCE_OUT;
                contact <= lfsr_nxt[0];
              end else begin
                state   <= DONE;
                contact <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          BOUNCE_OUT: begin
            if (cnt == BOUNCE_LAST) begin
              state   <= DONE;
              cnt     <= '0;
              contact <= 1'b0;
              done    <= 1'b1;
            end else begin
              cnt     <= cnt + CNT_W'(1);
              contact <= lfsr_nxt[0];
            end
          end
          DONE: begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            press_ready <= 1'b1;
          end
          default: begin
            state       <= IDLE;
            cnt         <= '0;
            contact     <= 1'b0;
            busy        <= 1'b0;
            press_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  // Only the latched row matters; other low rows never pull a column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cols <= 4'b1111;
    end else if (contact && !key_row[key_q[3:2]]) begin
      cols <= ~(4'b0001 << key_q[1:0]);
    end else begin
      cols <= 4'b1111;
    end
  end

endmodule
